// File: rtl/mips_mux_pkg.sv
// mips_mux_pkg: constants and helpers shared by the datapath muxes.
// Mode encodings, channel-index width rule and stall counter width.
package mips_mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;
    localparam int STALL_CNT_W  = 16;

    function automatic int chan_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_mux_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority search.
// Lowest requester at or above ptr wins, else lowest overall.
module rr_arbiter
    import mips_mux_pkg::*;
#(
    parameter  int N      = 4,
    localparam int CHAN_W = chan_w(N)
) (
    input  logic [N-1:0]      req,
    input  logic [CHAN_W-1:0] ptr,
    output logic [CHAN_W-1:0] grant,
    output logic              grant_valid
);

    logic [N-1:0] mask;
    logic [N-1:0] hi_req;

    assign mask        = {N{1'b1}} << ptr;
    assign hi_req      = req & mask;
    assign grant_valid = |req;

    // Wrapped search: requesters at/after ptr override the plain lowest one.
    always_comb begin
        grant = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) grant = CHAN_W'(j);
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (hi_req[j]) grant = CHAN_W'(j);
        end
    end

endmodule

// File: rtl/pipe_mux_arb.sv
// pipe_mux_arb: registered N-way mux/arbiter with valid/ready on all sides.
// Optional stall counter port enabled by `define PIPE_MUX_STALL_CNT_EN.
module pipe_mux_arb
    import mips_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int N      = 4,
    parameter  int MODE   = MUX_MODE_SEL,
    localparam int CHAN_W = chan_w(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    input  logic [CHAN_W-1:0]      sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [CHAN_W-1:0]      out_chan,
    output logic                   out_valid,
`ifdef PIPE_MUX_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    input  logic                   out_ready
);

    logic [CHAN_W-1:0] grant;
    logic              grant_valid;
    logic              accept;
    logic              xfer;
    logic              valid_g;
    logic [WIDTH-1:0]  data_g;

    logic [WIDTH-1:0]  data_q, data_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic              valid_q, valid_d;

    assign accept = !valid_q || out_ready;
    assign xfer   = valid_g && accept;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [CHAN_W-1:0] ptr_q, ptr_d;
            logic              unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(
                .N (N)
            ) u_arb (
                .req         (in_valid),
                .ptr         (ptr_q),
                .grant       (grant),
                .grant_valid (grant_valid)
            );

            // Winner drops to lowest priority after each transfer.
            always_comb begin
                ptr_d = ptr_q;
                if (xfer) begin
                    if (grant == CHAN_W'(N - 1)) ptr_d = '0;
                    else                         ptr_d = grant + 1'b1;
                end
            end

            // Round-robin pointer register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ptr_q <= '0;
                else        ptr_q <= ptr_d;
            end
        end else begin : g_sel
            assign grant = sel;
            if (N == (1 << CHAN_W)) begin : g_full
                assign grant_valid = 1'b1;
            end else begin : g_part
                assign grant_valid = (sel < CHAN_W'(N));
            end
        end
    endgenerate

    // Steer the granted channel through and hand accept back to it alone.
    always_comb begin
        valid_g  = 1'b0;
        data_g   = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_valid && grant == CHAN_W'(i)) begin
                valid_g     = in_valid[i];
                data_g      = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = accept;
            end
        end
    end

    // Load on transfer; a drained word with nothing behind it empties.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = data_g;
            chan_d  = grant;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output stage; reset drops any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

`ifdef PIPE_MUX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Count back-pressured cycles, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (valid_q && !out_ready && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_mux_arb.sv
// tb_pipe_mux_arb: scoreboard bench for select-mode (N=4, N=3)
// and round-robin (N=4) instances of pipe_mux_arb.
module tb_pipe_mux_arb;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [4*W-1:0] a_data;
    logic [3:0]     a_valid, a_rdy;
    logic [1:0]     a_sel, a_oc;
    logic [W-1:0]   a_od;
    logic           a_ov, a_or;

    logic [4*W-1:0] b_data;
    logic [3:0]     b_valid, b_rdy;
    logic [1:0]     b_sel, b_oc;
    logic [W-1:0]   b_od;
    logic           b_ov, b_or;

    logic [3*W-1:0] c_data;
    logic [2:0]     c_valid, c_rdy;
    logic [1:0]     c_sel, c_oc;
    logic [W-1:0]   c_od;
    logic           c_ov, c_or;

`ifdef PIPE_MUX_STALL_CNT_EN
    logic [15:0] a_sc, b_sc, c_sc;
`endif

    logic [33:0] qa[$];
    logic [33:0] qb[$];
    logic [33:0] qc[$];

    int n_chk;
    int n_pass;

    pipe_mux_arb #(.WIDTH(W), .N(4), .MODE(0)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_data),
        .in_valid  (a_valid),
        .in_ready  (a_rdy),
        .sel       (a_sel),
        .out_data  (a_od),
        .out_chan  (a_oc),
        .out_valid (a_ov),
`ifdef PIPE_MUX_STALL_CNT_EN
        .stall_cnt (a_sc),
`endif
        .out_ready (a_or)
    );

    pipe_mux_arb #(.WIDTH(W), .N(4), .MODE(1)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_data),
        .in_valid  (b_valid),
        .in_ready  (b_rdy),
        .sel       (b_sel),
        .out_data  (b_od),
        .out_chan  (b_oc),
        .out_valid (b_ov),
`ifdef PIPE_MUX_STALL_CNT_EN
        .stall_cnt (b_sc),
`endif
        .out_ready (b_or)
    );

    pipe_mux_arb #(.WIDTH(W), .N(3), .MODE(0)) u_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (c_data),
        .in_valid  (c_valid),
        .in_ready  (c_rdy),
        .sel       (c_sel),
        .out_data  (c_od),
        .out_chan  (c_oc),
        .out_valid (c_ov),
`ifdef PIPE_MUX_STALL_CNT_EN
        .stall_cnt (c_sc),
`endif
        .out_ready (c_or)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each word the consumer takes must match the queue head.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && a_ov && a_or) begin
            if (qa.size() == 0) begin
                chk("a_unexpected", 64'(qa.size()), 64'(1));
            end else begin
                e = qa.pop_front();
                chk("a_out", 64'({a_oc, a_od}), 64'(e));
            end
        end
        if (rst_n && b_ov && b_or) begin
            if (qb.size() == 0) begin
                chk("b_unexpected", 64'(qb.size()), 64'(1));
            end else begin
                e = qb.pop_front();
                chk("b_out", 64'({b_oc, b_od}), 64'(e));
            end
        end
        if (rst_n && c_ov && c_or) begin
            if (qc.size() == 0) begin
                chk("c_unexpected", 64'(qc.size()), 64'(1));
            end else begin
                e = qc.pop_front();
                chk("c_out", 64'({c_oc, c_od}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int m;
        logic [3:0] oh;
        n_chk = 0;
        n_pass = 0;
        a_data = '0; a_valid = '0; a_sel = '0; a_or = 1'b1;
        b_data = '0; b_valid = '0; b_sel = '0; b_or = 1'b1;
        c_data = '0; c_valid = '0; c_sel = '0; c_or = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ov", 64'(a_ov), 64'(0));
        chk("rst_a_od", 64'(a_od), 64'(0));
        chk("rst_a_oc", 64'(a_oc), 64'(0));
        chk("rst_b_ov", 64'(b_ov), 64'(0));
        chk("rst_c_ov", 64'(c_ov), 64'(0));
        #1 rst_n = 1'b1;
        step();

        // MODE 0 select channel 2
        a_sel = 2'd2;
        a_data[2*W +: W] = 32'hDEADBEEF;
        a_valid = 4'b0100;
        qa.push_back({2'd2, 32'hDEADBEEF});
        @(negedge clk);
        chk("a_rdy_sel2", 64'(a_rdy), 64'(4'b0100));
        step();
        a_valid = '0;
        @(negedge clk);
        chk("a_latency", 64'(a_ov), 64'(1));
        step();
        @(negedge clk);
        chk("a_drain_ov", 64'(a_ov), 64'(0));
        chk("a_hold_oc", 64'(a_oc), 64'(2));
        chk("a_hold_od", 64'(a_od), 64'(32'hDEADBEEF));
        step();

        // backpressure with sel changes while stalled
        a_or = 1'b0;
        a_sel = 2'd0;
        a_data[0 +: W] = 32'h77;
        a_valid = 4'b0001;
        qa.push_back({2'd0, 32'h77});
        step();
        a_data[W +: W] = 32'h5;
        a_data[3*W +: W] = 32'h33;
        a_valid = 4'b1010;
        a_sel = 2'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rdy", 64'(a_rdy), 64'(0));
            chk("bp_od", 64'(a_od), 64'(32'h77));
            chk("bp_ov", 64'(a_ov), 64'(1));
            step();
            a_sel = (k % 2 == 0) ? 2'd1 : 2'd3;
        end
`ifdef PIPE_MUX_STALL_CNT_EN
        chk("stall_cnt5", 64'(a_sc), 64'(5));
`endif
        a_sel = 2'd1;
        a_valid = 4'b0010;
        a_or = 1'b1;
        qa.push_back({2'd1, 32'h5});
        @(negedge clk);
        chk("rel_rdy", 64'(a_rdy), 64'(4'b0010));
        step();
        a_valid = '0;
        @(negedge clk);
        chk("rel_ov", 64'(a_ov), 64'(1));
        step();
`ifdef PIPE_MUX_STALL_CNT_EN
        chk("stall_hold", 64'(a_sc), 64'(5));
`endif

        // async reset while a word is held
        a_or = 1'b0;
        a_sel = 2'd1;
        a_data[W +: W] = 32'hAA;
        a_valid = 4'b0010;
        step();
        a_valid = '0;
        @(negedge clk);
        chk("pre_rst_ov", 64'(a_ov), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ov", 64'(a_ov), 64'(0));
        chk("arst_od", 64'(a_od), 64'(0));
        chk("arst_oc", 64'(a_oc), 64'(0));
`ifdef PIPE_MUX_STALL_CNT_EN
        chk("arst_sc", 64'(a_sc), 64'(0));
`endif
        step();
        rst_n = 1'b1;
        a_or = 1'b1;
        a_sel = 2'd0;
        a_data[0 +: W] = 32'h11;
        a_valid = 4'b0001;
        qa.push_back({2'd0, 32'h11});
        step();
        a_valid = '0;
        @(negedge clk);
        chk("post_rst_lat", 64'(a_ov), 64'(1));
        step();

        // MODE 1: lone ch3, then ch1|ch3 from ptr 0
        b_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        b_valid = 4'b1000;
        qb.push_back({2'd3, 32'hB3});
        @(negedge clk);
        chk("rr_rdy3", 64'(b_rdy), 64'(4'b1000));
        step();
        b_valid = 4'b1010;
        qb.push_back({2'd1, 32'hB1});
        @(negedge clk);
        chk("rr_rdy1", 64'(b_rdy), 64'(4'b0010));
        step();

        // MODE 1: all valid, ptr now 2, one word per cycle
        b_valid = 4'b1111;
        m = 2;
        for (int k = 0; k < 8; k++) begin
            oh = 4'(1 << m);
            qb.push_back({2'(m), 32'hB0 + 32'(m)});
            @(negedge clk);
            chk("rr_rdy_seq", 64'(b_rdy), 64'(oh));
            if (k > 0) chk("rr_tput", 64'(b_ov), 64'(1));
            step();
            m = (m + 1) % 4;
        end
        b_valid = '0;
        @(negedge clk);
        chk("rr_last_ov", 64'(b_ov), 64'(1));
        step();

        // MODE 0, N=3: out-of-range select
        c_data = {32'hC2, 32'hC1, 32'hC0};
        c_valid = 3'b111;
        c_sel = 2'd3;
        @(negedge clk);
        chk("c_sel3_rdy", 64'(c_rdy), 64'(0));
        step();
        @(negedge clk);
        chk("c_sel3_ov", 64'(c_ov), 64'(0));
        step();
        c_sel = 2'd2;
        qc.push_back({2'd2, 32'hC2});
        @(negedge clk);
        chk("c_sel2_rdy", 64'(c_rdy), 64'(3'b100));
        step();
        c_valid = '0;
        @(negedge clk);
        chk("c_sel2_ov", 64'(c_ov), 64'(1));
        step();

        repeat (3) step();
        chk("qa_empty", 64'(qa.size()), 64'(0));
        chk("qb_empty", 64'(qb.size()), 64'(0));
        chk("qc_empty", 64'(qc.size()), 64'(0));
`ifdef PIPE_MUX_STALL_CNT_EN
        chk("b_sc_zero", 64'(b_sc), 64'(0));
        chk("c_sc_zero", 64'(c_sc), 64'(0));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
